// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB request arbiter slice.
// FSM state encoding, default bus widths and the response watchdog width.
package apb_arb_pkg;

  // Arbiter FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  // Response watchdog counter width (APB_ARB_TIMEOUT_EN builds only)
  localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
// Ports:
//   req  - request vector
//   ptr  - search start index
//   gnt  - one-hot grant (zero when no request)
//   idx  - binary index of the granted request
//   any  - at least one request is set
module rr_pick
  import apb_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest hit wins last
  always_comb begin
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      j = (32'(ptr) + 32'(off)) % NUM_REQ;
      if (req[IW'(j)]) begin
        gnt          = '0;
        gnt[IW'(j)]  = 1'b1;
        idx          = IW'(j);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master command port among NUM_REQ
// requesters, one outstanding transfer at a time, response routed back
// to the granted requester.
// Optional: define APB_ARB_TIMEOUT_EN for a response watchdog that ends a
// stalled transfer after TIMEOUT_CYCLES with rsp_error=1.
// Ports:
//   clk, rstn                      - clock, async active-low reset
//   req_valid/write/addr/wdata     - per-requester command (packed lanes)
//   req_ready                      - one-hot accept pulse (combinational)
//   rsp_valid/rdata/error          - one-hot response pulse + shared payload
//   m_valid/write/addr/wdata/ready - command port to apb_master
//   m_rsp_valid/rdata/error        - transfer completion from apb_master
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_error,
  output logic                  m_valid,
  output logic                  m_write,
  output logic [AW-1:0]         m_addr,
  output logic [DW-1:0]         m_wdata,
  input  logic                  m_ready,
  input  logic                  m_rsp_valid,
  input  logic [DW-1:0]         m_rsp_rdata,
  input  logic                  m_rsp_error
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter range checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("apb_req_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TMO_W)) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES out of counter range");
  end

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               m_valid_d, m_write_d;
  logic [AW-1:0]      m_addr_d;
  logic [DW-1:0]      m_wdata_d;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_d;
  logic               rsp_error_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               sel_write;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Accept only in IDLE; gated by rstn so reset forces every output low
  always_comb begin
    req_ready = '0;
    if (rstn && state_q == IDLE) req_ready = pick_gnt;
  end

  // Command field mux for the picked requester
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_idx == IW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    m_valid_d   = m_valid;
    m_write_d   = m_write;
    m_addr_d    = m_addr;
    m_wdata_d   = m_wdata;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    rsp_error_d = rsp_error;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d   = pick_idx;
          m_write_d = sel_write;
          m_addr_d  = sel_addr;
          m_wdata_d = sel_wdata;
          m_valid_d = 1'b1;
          ptr_d     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
          state_d   = CMD;
        end
      end
      CMD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = WAIT;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
      end
      WAIT: begin
        if (m_rsp_valid) begin
          rsp_rdata_d          = m_write ? '0 : m_rsp_rdata;
          rsp_error_d          = m_rsp_error;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rsp_rdata_d          = '0;
          rsp_error_d          = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      m_valid   <= 1'b0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      m_valid   <= m_valid_d;
      m_write   <= m_write_d;
      m_addr    <= m_addr_d;
      m_wdata   <= m_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_error <= rsp_error_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: table-driven single transfers,
// reset mid-transfer, round-robin fairness and (with APB_ARB_TIMEOUT_EN)
// the response watchdog. Responses are checked through a scoreboard queue.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, m_wdata, m_rsp_rdata;
  logic              rsp_error, m_valid, m_write, m_ready, m_rsp_valid, m_rsp_error;
  logic [AW-1:0]     m_addr;

  apb_req_arbiter #(
    .NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_error(m_rsp_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int unsigned   idx;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int unsigned   s_wait;
    logic [DW-1:0] s_rdata;
    logic          s_err;
    logic [DW-1:0] e_rdata;
    logic          e_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int unsigned i);
    return NR'(1) << i;
  endfunction

  // apb_master model: m_ready in the cycle m_valid is seen, then m_rsp_valid
  // in the slv_wait-th WAIT cycle
  int unsigned   slv_wait  = 1;
  logic          slv_en    = 1'b1;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err   = 1'b0;
  int            s_phase   = 0;
  int unsigned   s_cnt     = 0;

  initial begin
    m_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_error = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        s_phase = 0; m_ready = 1'b0; m_rsp_valid = 1'b0;
        m_rsp_rdata = '0; m_rsp_error = 1'b0;
      end else begin
        case (s_phase)
          0: if (slv_en && m_valid) begin m_ready = 1'b1; s_phase = 1; end
          1: begin
            m_ready = 1'b0;
            if (slv_wait <= 1) begin
              m_rsp_valid = 1'b1; m_rsp_rdata = slv_rdata; m_rsp_error = slv_err; s_phase = 3;
            end else begin
              s_cnt = slv_wait - 1; s_phase = 2;
            end
          end
          2: begin
            s_cnt--;
            if (s_cnt == 0) begin
              m_rsp_valid = 1'b1; m_rsp_rdata = slv_rdata; m_rsp_error = slv_err; s_phase = 3;
            end
          end
          default: begin
            m_rsp_valid = 1'b0; m_rsp_rdata = '0; m_rsp_error = 1'b0; s_phase = 0;
          end
        endcase
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(oh(e.idx)));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_error", 64'(rsp_error), 64'(e.err));
          if (e.cyc >= 0) chk("rsp_latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic set_req(input int unsigned i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Called at negedge+1; polls up to 40 cycles for an accept pulse
  task automatic wait_grant(output logic [NR-1:0] g, output int c);
    for (int k = 0; k < 40; k++) begin
      if (req_ready != '0) break;
      @(negedge clk); #1;
    end
    g = req_ready;
    c = cyc;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_pending", 64'(sb.size()), 64'(0));
    sb.delete();
    for (int k = 0; k < 400 && s_phase != 0; k++) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(0));
    chk({tag, "_m_valid"},   64'(m_valid),   64'(0));
    chk({tag, "_m_write"},   64'(m_write),   64'(0));
    chk({tag, "_m_addr"},    64'(m_addr),    64'(0));
    chk({tag, "_m_wdata"},   64'(m_wdata),   64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[6];
    vec_t          v;
    logic [NR-1:0] g;
    int            c;
    int unsigned   exp_ptr;
    int unsigned   ex;

    vecs[0] = '{2, 1'b1, 32'h10,       32'hA5,       1, 32'h1234,     1'b0, 32'h0,        1'b0};
    vecs[1] = '{1, 1'b0, 32'h20,       32'h0,        4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{3, 1'b1, 32'h30,       32'h5555AAAA, 2, 32'h77,       1'b1, 32'h0,        1'b1};
    vecs[3] = '{0, 1'b0, 32'h40,       32'h0,        1, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 1'b0};
    vecs[4] = '{0, 1'b0, 32'h44,       32'h0,        3, 32'h00000BAD, 1'b1, 32'h00000BAD, 1'b1};
    vecs[5] = '{3, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 1, 32'h0,        1'b0, 32'h0,        1'b0};

    rstn = 1'b0;
    req_valid = 4'b0100; req_write = '0; req_addr = '0; req_wdata = '0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;
    exp_ptr = 0;

    // Table: one requester at a time, checks grant, command fields, response
    for (int t = 0; t < 6; t++) begin
      v = vecs[t];
      @(negedge clk);
      slv_wait = v.s_wait; slv_rdata = v.s_rdata; slv_err = v.s_err;
      set_req(v.idx, v.write, v.addr, v.wdata);
      #1;
      wait_grant(g, c);
      chk("tbl_grant", 64'(g), 64'(oh(v.idx)));
      sb.push_back('{v.idx, v.e_rdata, v.e_err, c + 2 + int'(v.s_wait)});
      exp_ptr = (v.idx + 1) % NR;
      @(negedge clk);
      req_valid = '0;
      chk("tbl_m_valid", 64'(m_valid), 64'(1));
      chk("tbl_m_write", 64'(m_write), 64'(v.write));
      chk("tbl_m_addr",  64'(m_addr),  64'(v.addr));
      chk("tbl_m_wdata", 64'(m_wdata), 64'(v.wdata));
      drain();
      chk("tbl_rsp_hold", 64'(rsp_rdata), 64'(v.e_rdata));
    end

    // Reset during WAIT abandons the transfer and restarts the pointer at 0
    @(negedge clk);
    slv_wait = 50; slv_rdata = 32'h11; slv_err = 1'b0;
    set_req(2, 1'b0, 32'h200, 32'h0);
    #1;
    wait_grant(g, c);
    chk("rst_pre_grant", 64'(g), 64'(oh(2)));
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    set_req(1, 1'b0, 32'h104, 32'h0);
    set_req(3, 1'b1, 32'h30C, 32'h33);
    #1;
    chk("no_ready_in_wait", 64'(req_ready), 64'(0));
    #2;
    rstn = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_ptr = 0;
    repeat (2) @(negedge clk);
    slv_wait = 2; slv_rdata = 32'h0F0F0F0F; slv_err = 1'b0;
    rstn = 1'b1;
    #1;
    wait_grant(g, c);
    chk("rst_first_grant", 64'(g), 64'(oh(1)));
    sb.push_back('{1, 32'h0F0F0F0F, 1'b0, -1});
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    wait_grant(g, c);
    chk("rst_second_grant", 64'(g), 64'(oh(3)));
    sb.push_back('{3, 32'h0, 1'b0, c + 4});
    exp_ptr = 0;
    @(negedge clk);
    req_valid = '0;
    drain();

    // All requesters continuously valid: grants rotate from the pointer
    @(negedge clk);
    slv_wait = 1; slv_rdata = 32'h5A5A0000; slv_err = 1'b0;
    for (int i = 0; i < int'(NR); i++)
      set_req(i, (i % 2) == 1, 32'h1000 + 32'(i) * 16, 32'hD0 + 32'(i));
    #1;
    for (int k = 0; k < 8; k++) begin
      ex = exp_ptr;
      wait_grant(g, c);
      chk("rr_grant", 64'(g), 64'(oh(ex)));
      sb.push_back('{ex, ((ex % 2) == 1) ? 32'h0 : 32'h5A5A0000, 1'b0, c + 3});
      exp_ptr = (ex + 1) % NR;
      @(negedge clk);
      chk("rr_m_addr", 64'(m_addr), 64'(32'h1000 + 32'(ex) * 16));
      #1;
    end
    req_valid = '0;
    drain();

`ifdef APB_ARB_TIMEOUT_EN
    // Silent apb_master: watchdog answers with error; late response ignored
    @(negedge clk);
    slv_wait = TMO + 2; slv_rdata = 32'h99; slv_err = 1'b0;
    set_req(exp_ptr, 1'b0, 32'h50, 32'h0);
    #1;
    wait_grant(g, c);
    chk("tmo_grant", 64'(g), 64'(oh(exp_ptr)));
    sb.push_back('{exp_ptr, 32'h0, 1'b1, c + 2 + int'(TMO)});
    @(negedge clk);
    req_valid = '0;
    drain();
    repeat (3) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
